reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 164 ++++++++++++++++
 tb/tb_reg_file_mp.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file.
// Two write ports (port 1 wins on a collision) and two combinational read ports.
// Each entry has a pending bit. A pending bit is set by pend_set_en and cleared
// when a write to that entry is accepted.
// A clear FSM (IDLE -> SWEEP -> DONE) zeroes one entry per cycle. While it
// sweeps, the FSM locks out all writes, pend sets and clear requests.
// Optional build macro REG_FILE_MP_BYPASS_EN: reads forward same-cycle
// accepted write data. When the macro is absent, reads return stored state only.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd0_pend,
  output logic              rd1_pend,
  input  logic              pend_set_en,
  input  logic [ADDR_W-1:0] pend_set_addr,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DEPTH-1:0]    pend_q, pend_d;

  logic wr0_ok, wr1_ok, set_ok;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_pend [2];

  // Entry 0 is hard-wired to zero when ZERO_REG is enabled.
  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // The sweep locks out every update. Writes and sets are accepted in IDLE and DONE.
  assign wr0_ok = (state_q != ST_SWEEP) && wr0_en && !is_zero_addr(wr0_addr);
  assign wr1_ok = (state_q != ST_SWEEP) && wr1_en && !is_zero_addr(wr1_addr);
  assign set_ok = (state_q != ST_SWEEP) && pend_set_en && !is_zero_addr(pend_set_addr);

  // FSM state and sweep index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM next-state logic: the sweep visits idx 0..DEPTH-1, so it lasts DEPTH cycles.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(DEPTH - 1)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from state only
  always_comb begin
    clr_busy = 1'b0;
    clr_done = 1'b0;
    unique case (state_q)
      ST_SWEEP: clr_busy = 1'b1;
      ST_DONE:  clr_done = 1'b1;
      default:  ;
    endcase
  end

  // Array next state: sweep clear, or writes (port 1 last so it wins), then pend set last so it wins
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (state_q == ST_SWEEP) begin
      mem_d[idx_q]  = '0;
      pend_d[idx_q] = 1'b0;
    end else begin
      if (wr0_ok) begin
        mem_d[wr0_addr]  = wr0_data;
        pend_d[wr0_addr] = 1'b0;
      end
      if (wr1_ok) begin
        mem_d[wr1_addr]  = wr1_data;
        pend_d[wr1_addr] = 1'b0;
      end
      if (set_ok) pend_d[pend_set_addr] = 1'b1;
    end
  end

  // Storage array; the reset must clear all contents asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is reset on purpose (clear-on-reset is a functional requirement), which rules out RAM macros.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pend_q <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
    end
  end

  assign rd_addr[0] = rd0_addr;
  assign rd_addr[1] = rd1_addr;

  // Combinational read ports, with optional same-cycle write forwarding
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = mem_q[rd_addr[p]];
      rd_pend[p] = pend_q[rd_addr[p]];
`ifdef REG_FILE_MP_BYPASS_EN
      if (wr1_ok && (wr1_addr == rd_addr[p])) begin
        rd_data[p] = wr1_data;
        rd_pend[p] = set_ok && (pend_set_addr == rd_addr[p]);
      end else if (wr0_ok && (wr0_addr == rd_addr[p])) begin
        rd_data[p] = wr0_data;
        rd_pend[p] = set_ok && (pend_set_addr == rd_addr[p]);
      end
`endif
      if (is_zero_addr(rd_addr[p])) begin
        rd_data[p] = '0;
        rd_pend[p] = 1'b0;
      end
    end
  end

  assign rd0_data = rd_data[0];
  assign rd1_data = rd_data[1];
  assign rd0_pend = rd_pend[0];
  assign rd1_pend = rd_pend[1];

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp using default parameters (32 x 32, ZERO_REG=1).
// It uses a directed vector table, hand-written sweep and reset sequences,
// and a random phase checked against a behavioural model.
module tb_reg_file_mp;
  localparam int DW = 32;
  localparam int DEPTH = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr0_en, wr1_en, pend_set_en, clr_req;
  logic [AW-1:0] wr0_addr, wr1_addr, rd0_addr, rd1_addr, pend_set_addr;
  logic [DW-1:0] wr0_data, wr1_data, rd0_data, rd1_data;
  logic          rd0_pend, rd1_pend, clr_busy, clr_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the register file and the clear sweep
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_pend [DEPTH];
  int            sweep_left;
  logic          m_done;

  always #5 clk = ~clk;

  reg_file_mp dut (
    .clk(clk), .rst_n(rst_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .rd0_data(rd0_data), .rd1_data(rd1_data),
    .rd0_pend(rd0_pend), .rd1_pend(rd1_pend),
    .pend_set_en(pend_set_en), .pend_set_addr(pend_set_addr),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    sweep_left = 0;
    m_done     = 1'b0;
  endtask

  // One clock edge of the model, using the inputs currently applied
  task automatic model_update();
    logic was_done;
    if (sweep_left > 0) begin
      m_mem[DEPTH - sweep_left]  = '0;
      m_pend[DEPTH - sweep_left] = 1'b0;
      sweep_left--;
      if (sweep_left == 0) m_done = 1'b1;
    end else begin
      was_done = m_done;
      m_done   = 1'b0;
      if (wr0_en && wr0_addr != 0) begin m_mem[wr0_addr] = wr0_data; m_pend[wr0_addr] = 1'b0; end
      if (wr1_en && wr1_addr != 0) begin m_mem[wr1_addr] = wr1_data; m_pend[wr1_addr] = 1'b0; end
      if (pend_set_en && pend_set_addr != 0) m_pend[pend_set_addr] = 1'b1;
      if (!was_done && clr_req) sweep_left = DEPTH;
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REG_FILE_MP_BYPASS_EN
    if (sweep_left == 0) begin
      if (wr1_en && wr1_addr == a) return wr1_data;
      if (wr0_en && wr0_addr == a) return wr0_data;
    end
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REG_FILE_MP_BYPASS_EN
    if (sweep_left == 0 && ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a)))
      return pend_set_en && pend_set_addr == a;
`endif
    return m_pend[a];
  endfunction

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr0_en = 1'b0; wr1_en = 1'b0; pend_set_en = 1'b0; clr_req = 1'b0;
    wr0_addr = '0; wr1_addr = '0; pend_set_addr = '0;
    wr0_data = '0; wr1_data = '0;
  endtask

  typedef struct {
    logic          w0e; logic [AW-1:0] w0a; logic [DW-1:0] w0d;
    logic          w1e; logic [AW-1:0] w1a; logic [DW-1:0] w1d;
    logic          pse; logic [AW-1:0] psa;
    logic [AW-1:0] r0a; logic [AW-1:0] r1a;
    logic [DW-1:0] e0d; logic [DW-1:0] e1d;
    logic          e0p; logic          e1p;
  } vec_t;

  vec_t vecs [9];
  int   busy_cnt, done_cnt;

  initial begin
    // Each row: writes/sets applied for one edge, then reads checked with writes idle
    vecs[0] = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0, 32'h0,        0, 5'd0, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        0, 0};
    vecs[1] = '{1, 5'd7,  32'h11,       1, 5'd7, 32'h22,       0, 5'd0, 5'd7,  5'd5,  32'h22,       32'hDEADBEEF, 0, 0};
    vecs[2] = '{0, 5'd0,  32'h0,        1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        0, 0};
    vecs[3] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 5'd3, 5'd3,  5'd7,  32'h0,        32'h22,       1, 0};
    vecs[4] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd3,  5'd7,  32'h0,        32'h22,       1, 0};
    vecs[5] = '{1, 5'd3,  32'hA5,       0, 5'd0, 32'h0,        0, 5'd0, 5'd3,  5'd7,  32'hA5,       32'h22,       0, 0};
    vecs[6] = '{0, 5'd0,  32'h0,        1, 5'd3, 32'h5A,       1, 5'd3, 5'd3,  5'd0,  32'h5A,       32'h0,        1, 0};
    vecs[7] = '{1, 5'd9,  32'h1,        1, 5'd10, 32'h2,       0, 5'd0, 5'd9,  5'd10, 32'h1,        32'h2,        0, 0};
    vecs[8] = '{1, 5'd31, 32'h12345678, 0, 5'd0, 32'h0,        0, 5'd0, 5'd31, 5'd3,  32'h12345678, 32'h5A,       0, 1};

    // Reset state
    idle_inputs();
    rd0_addr = 5'd5; rd1_addr = 5'd31;
    rst_n = 1'b0;
    model_reset();
    #2;
    check("reset rd0_data", rd0_data, 32'h0);
    check("reset rd1_data", rd1_data, 32'h0);
    check("reset rd0_pend", 32'(rd0_pend), 32'h0);
    check("reset clr_busy", 32'(clr_busy), 32'h0);
    check("reset clr_done", 32'(clr_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int v = 0; v < 9; v++) begin
      wr0_en = vecs[v].w0e; wr0_addr = vecs[v].w0a; wr0_data = vecs[v].w0d;
      wr1_en = vecs[v].w1e; wr1_addr = vecs[v].w1a; wr1_data = vecs[v].w1d;
      pend_set_en = vecs[v].pse; pend_set_addr = vecs[v].psa;
      tick();
      idle_inputs();
      rd0_addr = vecs[v].r0a; rd1_addr = vecs[v].r1a;
      #1;
      check($sformatf("vec%0d rd0_data", v), rd0_data, vecs[v].e0d);
      check($sformatf("vec%0d rd1_data", v), rd1_data, vecs[v].e1d);
      check($sformatf("vec%0d rd0_pend", v), 32'(rd0_pend), 32'(vecs[v].e0p));
      check($sformatf("vec%0d rd1_pend", v), 32'(rd1_pend), 32'(vecs[v].e1p));
    end

    // Full sweep: fill everything, clear, and try to write mid-sweep
    for (int i = 0; i < DEPTH; i++) begin
      wr0_en = 1'b1; wr0_addr = AW'(i); wr0_data = 32'h1000 + 32'(i);
      pend_set_en = i[0]; pend_set_addr = AW'(i);
      tick();
    end
    idle_inputs();
    rd0_addr = 5'd17; rd1_addr = 5'd0;
    #1;
    check("fill rd0_data", rd0_data, 32'h1011);
    check("fill rd0_pend", 32'(rd0_pend), 32'h1);
    check("fill rd1_data", rd1_data, 32'h0);
    clr_req = 1'b1;
    tick();
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 45; c++) begin
      idle_inputs();
      if (c == 3) begin
        wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'hBAD0BAD0;
        wr1_en = 1'b1; wr1_addr = 5'd30; wr1_data = 32'hBAD1BAD1;
        pend_set_en = 1'b1; pend_set_addr = 5'd6; clr_req = 1'b1;
      end
      #1;
      if (clr_busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) done_cnt++;
      check($sformatf("sweep c%0d busy", c), 32'(clr_busy), 32'(sweep_left > 0));
      tick();
    end
    check("sweep busy cycles", 32'(busy_cnt), 32'd32);
    check("sweep done pulses", 32'(done_cnt), 32'd1);
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      rd0_addr = AW'(i);
      #1;
      check($sformatf("swept data[%0d]", i), rd0_data, 32'h0);
      check($sformatf("swept pend[%0d]", i), 32'(rd0_pend), 32'h0);
    end

    // Reset during a sweep
    for (int i = 1; i < 9; i++) begin
      wr0_en = 1'b1; wr0_addr = AW'(i); wr0_data = 32'hA000 + 32'(i);
      pend_set_en = 1'b1; pend_set_addr = AW'(i + 9);
      tick();
    end
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("midsweep busy before reset", 32'(clr_busy), 32'h1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async reset busy", 32'(clr_busy), 32'h0);
    check("async reset done", 32'(clr_done), 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      rd0_addr = AW'(i); rd1_addr = AW'(i);
      #1;
      if (i > 0 && i < 18) begin
        check($sformatf("rst data[%0d]", i), rd0_data, 32'h0);
        check($sformatf("rst pend[%0d]", i), 32'(rd1_pend), 32'h0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    wr0_en = 1'b1; wr0_addr = 5'd6; wr0_data = 32'hCAFE0006;
    tick();
    idle_inputs();
    rd0_addr = 5'd6;
    #1;
    check("first edge after reset write", rd0_data, 32'hCAFE0006);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (clr_done === 1'b1) done_cnt++;
      tick();
    end
    check("no done after aborted sweep", 32'(done_cnt), 32'h0);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      wr0_en = 1'($urandom_range(0, 1)); wr0_addr = AW'($urandom_range(0, 7)); wr0_data = $urandom;
      wr1_en = 1'($urandom_range(0, 1)); wr1_addr = AW'($urandom_range(0, 7)); wr1_data = $urandom;
      pend_set_en = 1'($urandom_range(0, 1)); pend_set_addr = AW'($urandom_range(0, 7));
      clr_req = ($urandom_range(0, 59) == 0);
      rd0_addr = AW'($urandom_range(0, 7)); rd1_addr = AW'($urandom_range(0, 31));
      #1;
      check("rand rd0_data", rd0_data, exp_data(rd0_addr));
      check("rand rd1_data", rd1_data, exp_data(rd1_addr));
      check("rand rd0_pend", 32'(rd0_pend), 32'(exp_pend(rd0_addr)));
      check("rand rd1_pend", 32'(rd1_pend), 32'(exp_pend(rd1_addr)));
      check("rand clr_busy", 32'(clr_busy), 32'(sweep_left > 0));
      check("rand clr_done", 32'(clr_done), 32'(m_done));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
